change_dispense_ctrl: RTL and testbench

- Sequences the coin-return mechanism of the vending machine.
- On a start request it accepts a change amount in cents. It then ejects quarters, dimes and nickels one coin at a time using a greedy largest-coin-first order, limited by per-tube inventory.
- Each ejection is a handshake with the coin mechanism.
- It sits between the vending FSM (which produces the change/cancel refund) and the physical coin-eject solenoids. It tracks tube inventory and reports any amount it could not pay.

---
 rtl/change_dispense_ctrl.sv | 126 ++++++++++++
 tb/tb_change_dispense_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispense_ctrl.sv
// Coin-return sequencer: pays a change amount greedily (quarter, dime, nickel)
// from three inventoried tubes, one handshaked ejection at a time.
module change_dispense_ctrl #(
    parameter int AMT_W       = 9,
    parameter int CNT_W       = 6,
    parameter int TUBE_MAX    = 63,
    parameter int TUBE_INIT   = 20,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    output logic [2:0]       coin_eject,
    input  logic             coin_ack,
    input  logic [2:0]       refill_coin,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] short_amt,
    output logic             jam,
    output logic [CNT_W-1:0] q_cnt,
    output logic [CNT_W-1:0] d_cnt,
    output logic [CNT_W-1:0] n_cnt
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SELECT, EJECT, FINISH} state_t;

    state_t           state;
    logic [AMT_W-1:0] remaining;
    logic [TW-1:0]    timer;
    logic [AMT_W-1:0] coin_val;
    logic [2:0]       dec;

    // A tube is only decremented by an accepted ack for the coin currently commanded.
    assign dec = (state == EJECT && coin_ack) ? coin_eject : 3'b000;

    always_comb begin
        coin_val = '0;
        if (coin_eject[2])      coin_val = AMT_W'(25);
        else if (coin_eject[1]) coin_val = AMT_W'(10);
        else if (coin_eject[0]) coin_val = AMT_W'(5);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            timer      <= '0;
            coin_eject <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            short_amt  <= '0;
            jam        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= change_amt;
                        short_amt <= '0;
                        jam       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (change_amt == '0) ? FINISH : SELECT;
                    end
                end
                SELECT: begin
                    timer <= '0;
                    if (remaining >= AMT_W'(25) && q_cnt != '0) begin
                        coin_eject <= 3'b100;
                        state      <= EJECT;
                    end else if (remaining >= AMT_W'(10) && d_cnt != '0) begin
                        coin_eject <= 3'b010;
                        state      <= EJECT;
                    end else if (remaining >= AMT_W'(5) && n_cnt != '0) begin
                        coin_eject <= 3'b001;
                        state      <= EJECT;
                    end else begin
                        state <= FINISH;
                    end
                end
                EJECT: begin
                    // An ack arriving on the last timeout cycle still counts the coin.
                    if (coin_ack) begin
                        remaining  <= remaining - coin_val;
                        coin_eject <= 3'b000;
                        state      <= (remaining == coin_val) ? FINISH : SELECT;
                    end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                        jam        <= 1'b1;
                        coin_eject <= 3'b000;
                        state      <= FINISH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FINISH: begin
                    short_amt <= remaining;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tube inventories; index 2 = quarter, 1 = dime, 0 = nickel, matching coin_eject.
    for (genvar gi = 0; gi < 3; gi++) begin : g_tube
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= CNT_W'(TUBE_INIT);
            end else if (refill_coin[gi] && !dec[gi]) begin
                if (cnt != CNT_W'(TUBE_MAX)) cnt <= cnt + 1'b1;
            end else if (dec[gi] && !refill_coin[gi]) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign q_cnt = g_tube[2].cnt;
    assign d_cnt = g_tube[1].cnt;
    assign n_cnt = g_tube[0].cnt;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: greedy payout, inventory limits,
// jam timeout, refill saturation/collision and reset during ejection.
module tb_change_dispense_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] change_amt;
    logic [2:0] coin_eject;
    logic       coin_ack;
    logic [2:0] refill_coin;
    logic       busy;
    logic       done;
    logic [8:0] short_amt;
    logic       jam;
    logic [5:0] q_cnt;
    logic [5:0] d_cnt;
    logic [5:0] n_cnt;

    int checks = 0;
    int errors = 0;

    change_dispense_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .change_amt (change_amt),
        .coin_eject (coin_eject),
        .coin_ack   (coin_ack),
        .refill_coin(refill_coin),
        .busy       (busy),
        .done       (done),
        .short_amt  (short_amt),
        .jam        (jam),
        .q_cnt      (q_cnt),
        .d_cnt      (d_cnt),
        .n_cnt      (n_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Runs one payout; k counts clock edges after the edge that accepted start.
    task automatic dispense(input int amt, input bit ack_en, input logic [2:0] rf_ack,
                            output logic [23:0] seq, output int ncoin,
                            output int done_cyc, output int eject_hi);
        seq = '0; ncoin = 0; done_cyc = -1; eject_hi = 0;
        start = 1'b1;
        change_amt = 9'(amt);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            coin_ack = 1'b0;
            refill_coin = 3'b000;
            if (done) begin
                done_cyc = k;
                break;
            end
            if (coin_eject != 3'b000) begin
                eject_hi++;
                if (ack_en) begin
                    coin_ack = 1'b1;
                    refill_coin = rf_ack;
                    seq = {seq[20:0], coin_eject};
                    ncoin++;
                end
            end
        end
        coin_ack = 1'b0;
        refill_coin = 3'b000;
        check("done_seen", 32'(done_cyc >= 0), 1);
        $display("txn amt=%0d coins=%0d done_cyc=%0d short=%0d jam=%0d q=%0d d=%0d n=%0d",
                 amt, ncoin, done_cyc, short_amt, jam, q_cnt, d_cnt, n_cnt);
    endtask

    task automatic refill(input logic [2:0] bits, input int n);
        refill_coin = bits;
        for (int i = 0; i < n; i++) @(negedge clk);
        refill_coin = 3'b000;
        $display("txn refill bits=%b x%0d q=%0d d=%0d n=%0d", bits, n, q_cnt, d_cnt, n_cnt);
    endtask

    initial begin
        logic [23:0] seq;
        logic [23:0] exp_seq;
        int ncoin, done_cyc, eject_hi;

        rst_n = 1'b0; start = 1'b0; change_amt = '0; coin_ack = 1'b0; refill_coin = 3'b000;
        repeat (2) @(negedge clk);
        check("rst_eject", coin_eject, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_jam", jam, 0);
        check("rst_short", short_amt, 0);
        check("rst_q", q_cnt, 20);
        check("rst_d", d_cnt, 20);
        check("rst_n_cnt", n_cnt, 20);
        rst_n = 1'b1;
        @(negedge clk);

        // 40 cents: quarter, dime, nickel
        dispense(40, 1'b1, 3'b000, seq, ncoin, done_cyc, eject_hi);
        exp_seq = {15'd0, 3'b100, 3'b010, 3'b001};
        check("c40_seq", seq, exp_seq);
        check("c40_ncoin", ncoin, 3);
        check("c40_latency", done_cyc, 7);
        check("c40_short", short_amt, 0);
        check("c40_busy", busy, 0);
        check("c40_q", q_cnt, 19);
        check("c40_d", d_cnt, 19);
        check("c40_n", n_cnt, 19);
        @(negedge clk);
        check("c40_done_pulse", done, 0);

        // Drain quarters, then dimes down to 3, then add one quarter
        dispense(475, 1'b1, 3'b000, seq, ncoin, done_cyc, eject_hi);
        check("drainq_ncoin", ncoin, 19);
        check("drainq_q", q_cnt, 0);
        dispense(160, 1'b1, 3'b000, seq, ncoin, done_cyc, eject_hi);
        check("draind_ncoin", ncoin, 16);
        check("draind_d", d_cnt, 3);
        refill(3'b100, 1);
        check("refill_q1", q_cnt, 1);

        // 65 cents with one quarter and three dimes: Q D D D N N
        dispense(65, 1'b1, 3'b000, seq, ncoin, done_cyc, eject_hi);
        exp_seq = {6'd0, 3'b100, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001};
        check("c65_seq", seq, exp_seq);
        check("c65_latency", done_cyc, 13);
        check("c65_short", short_amt, 0);
        check("c65_q", q_cnt, 0);
        check("c65_d", d_cnt, 0);
        check("c65_n", n_cnt, 17);

        // 7 cents: one nickel, 2 cents unpaid
        dispense(7, 1'b1, 3'b000, seq, ncoin, done_cyc, eject_hi);
        check("c7_seq", seq, 24'd1);
        check("c7_latency", done_cyc, 4);
        check("c7_short", short_amt, 2);
        check("c7_n", n_cnt, 16);

        // Empty every tube, then request 25
        dispense(80, 1'b1, 3'b000, seq, ncoin, done_cyc, eject_hi);
        check("drainn_ncoin", ncoin, 16);
        check("drainn_n", n_cnt, 0);
        dispense(25, 1'b1, 3'b000, seq, ncoin, done_cyc, eject_hi);
        check("empty_eject", eject_hi, 0);
        check("empty_latency", done_cyc, 2);
        check("empty_short", short_amt, 25);

        // Ack never arrives: jam after 15 eject cycles
        refill(3'b100, 1);
        dispense(25, 1'b0, 3'b000, seq, ncoin, done_cyc, eject_hi);
        check("jam_eject_cycles", eject_hi, 15);
        check("jam_latency", done_cyc, 17);
        check("jam_flag", jam, 1);
        check("jam_short", short_amt, 25);
        check("jam_q", q_cnt, 1);
        dispense(0, 1'b1, 3'b000, seq, ncoin, done_cyc, eject_hi);
        check("zero_latency", done_cyc, 1);
        check("jam_cleared", jam, 0);
        check("zero_short", short_amt, 0);

        // Quarter refill colliding with quarter ack nets to zero
        dispense(25, 1'b1, 3'b100, seq, ncoin, done_cyc, eject_hi);
        check("collide_ncoin", ncoin, 1);
        check("collide_latency", done_cyc, 3);
        check("collide_q", q_cnt, 1);

        // Nickel tube saturates at 63
        refill(3'b001, 63);
        check("sat_n63", n_cnt, 63);
        refill(3'b001, 5);
        check("sat_n_hold", n_cnt, 63);

        // Start while busy must not relatch change_amt
        start = 1'b1; change_amt = 9'd25;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_eject", coin_eject, 3'b100);
        start = 1'b1; change_amt = 9'd10; coin_ack = 1'b1;
        @(negedge clk);
        start = 1'b0; coin_ack = 1'b0;
        check("busy_still", busy, 1);
        @(negedge clk);
        check("busy_done", done, 1);
        check("busy_short", short_amt, 0);
        check("busy_q", q_cnt, 0);
        check("busy_d", d_cnt, 0);
        $display("txn start-while-busy short=%0d q=%0d d=%0d", short_amt, q_cnt, d_cnt);
        @(negedge clk);

        // Asynchronous reset in the middle of an ejection
        refill(3'b100, 1);
        start = 1'b1; change_amt = 9'd25;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("arst_pre_eject", coin_eject, 3'b100);
        #2 rst_n = 1'b0;
        #1;
        check("arst_eject", coin_eject, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_q", q_cnt, 20);
        check("arst_n", n_cnt, 20);
        $display("txn async reset mid-eject eject=%b busy=%0d", coin_eject, busy);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_idle_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
